// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and control-bundle types for the pipeline control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU control codes
  localparam int ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  // Operand forwarding selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Control carried into EX (everything decode produces)
  typedef struct packed {
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src_b;
    logic             branch;
    logic             bne;
    logic             mem_write;
    logic             mem2reg;
    logic [ALU_W-1:0] alu_ctl;
  } ctrl_e_t;

  // Control still needed once the instruction leaves EX
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem2reg;
  } ctrl_m_t;

  // Control still needed in WB
  typedef struct packed {
    logic reg_write;
    logic mem2reg;
  } ctrl_w_t;

  localparam int CTRL_E_W = $bits(ctrl_e_t);
  localparam int CTRL_M_W = $bits(ctrl_m_t);
  localparam int CTRL_W_W = $bits(ctrl_w_t);

  localparam ctrl_e_t CTRL_NOP = '0;

  // MEM has priority over WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit) return FWD_MEM;
    if (wb_hit)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Datapath <-> control-unit signal bundle.
// Latency: n/a (wiring only).
// Backpressure: stall/flush travel back to the datapath through this bundle.
interface pipeline_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int ALU_CW = 3
);
  // Datapath -> control
  logic [5:0]        opD;
  logic [5:0]        functD;
  logic [REG_AW-1:0] rsD;
  logic [REG_AW-1:0] rtD;
  logic [REG_AW-1:0] rsE;
  logic [REG_AW-1:0] rtE;
  logic [REG_AW-1:0] writeRegM;
  logic [REG_AW-1:0] writeRegW;
  logic              zeroE;

  // Control -> datapath
  logic              regDst;
  logic              aluSrcB;
  logic [ALU_CW-1:0] aluControl;
  logic [1:0]        fad;
  logic [1:0]        fbd;
  logic              memWrite;
  logic              regWrite;
  logic              mem2Reg;
  logic              pcSrc;
  logic              flush;
  logic              stall;
  logic              illegal;

  // Datapath side
  modport master (
    output opD, functD, rsD, rtD, rsE, rtE, writeRegM, writeRegW, zeroE,
    input  regDst, aluSrcB, aluControl, fad, fbd, memWrite, regWrite, mem2Reg,
           pcSrc, flush, stall, illegal
  );

  // Control-unit side
  modport slave (
    input  opD, functD, rsD, rtD, rsE, rtE, writeRegM, writeRegW, zeroE,
    output regDst, aluSrcB, aluControl, fad, fbd, memWrite, regWrite, mem2Reg,
           pcSrc, flush, stall, illegal
  );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational opcode/funct decode into the EX control bundle plus an illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the bundle is used.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  logic [5:0] op_d,
  input  logic [5:0] funct_d,
  output ctrl_e_t    ctrl,
  output logic       illegal
);

  // Undecodable encodings collapse to an all-zero bundle and raise illegal.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op_d)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct_d)
          FN_ADD:  ctrl.alu_ctl = ALU_ADD;
          FN_SUB:  ctrl.alu_ctl = ALU_SUB;
          FN_AND:  ctrl.alu_ctl = ALU_AND;
          FN_OR:   ctrl.alu_ctl = ALU_OR;
          FN_SLT:  ctrl.alu_ctl = ALU_SLT;
          default: begin
            ctrl    = CTRL_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.mem2reg   = 1'b1;
        ctrl.alu_ctl   = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctl   = ALU_ADD;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_ctl   = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_ctl = ALU_SUB;
      end
      OP_BNE: begin
        if (BNE_EN) begin
          ctrl.branch  = 1'b1;
          ctrl.bne     = 1'b1;
          ctrl.alu_ctl = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Control and hazard sequencer for a 5-stage pipeline: decode, stage control regs, forwarding, stall, branch flush.
// Latency: EX controls 1 cycle after ID, MEM controls 2, WB controls 3; hazard outputs are same-cycle.
// Backpressure: load-use raises stall (PC/IF-ID hold, bubble into EX); a taken branch raises flush and wins over stall.
module pipeline_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int ALU_CW = 3,
  parameter bit BNE_EN = 1'b1
) (
  input logic                clk,
  input logic                rst,
  pipeline_ctrl_unit_if.slave pcu
);

  logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wr_reg_m, wr_reg_w;

  assign rs_d     = pcu.rsD;
  assign rt_d     = pcu.rtD;
  assign rs_e     = pcu.rsE;
  assign rt_e     = pcu.rtE;
  assign wr_reg_m = pcu.writeRegM;
  assign wr_reg_w = pcu.writeRegW;

  ctrl_e_t dec_ctrl;
  logic    dec_illegal;

  ctrl_decoder #(.BNE_EN(BNE_EN)) u_decoder (
    .op_d    (pcu.opD),
    .funct_d (pcu.functD),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  ctrl_e_t ctrl_e_q, ctrl_e_d;
  ctrl_m_t ctrl_m_q, ctrl_m_d;
  ctrl_w_t ctrl_w_q, ctrl_w_d;
  logic    illegal_q, illegal_d;

  logic       pc_src;
  logic       load_use;
  logic       stall_hz;
  logic       mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b;
  logic [1:0] fad_sel, fbd_sel;

  // Branch resolution and load-use detection; only registered EX state and live register numbers feed these.
  // A load and a branch never occupy EX together, but flush still masks stall so the discarded ID slot is not held.
  always_comb begin
    pc_src   = ctrl_e_q.branch & (pcu.zeroE ^ ctrl_e_q.bne);
    load_use = ctrl_e_q.mem2reg && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
    stall_hz = load_use & ~pc_src;
  end

  // Operand forwarding from the MEM and WB producers; register 0 is never forwarded.
  always_comb begin
    mem_hit_a = ctrl_m_q.reg_write && (wr_reg_m != '0) && (wr_reg_m == rs_e);
    wb_hit_a  = ctrl_w_q.reg_write && (wr_reg_w != '0) && (wr_reg_w == rs_e);
    mem_hit_b = ctrl_m_q.reg_write && (wr_reg_m != '0) && (wr_reg_m == rt_e);
    wb_hit_b  = ctrl_w_q.reg_write && (wr_reg_w != '0) && (wr_reg_w == rt_e);
    fad_sel   = fwd_sel(mem_hit_a, wb_hit_a);
    fbd_sel   = fwd_sel(mem_hit_b, wb_hit_b);
  end

  // Next stage contents: a bubble enters EX on stall or flush; older stages simply advance.
  always_comb begin
    ctrl_e_d           = (pc_src || stall_hz) ? CTRL_NOP : dec_ctrl;
    ctrl_m_d           = '0;
    ctrl_m_d.reg_write = ctrl_e_q.reg_write;
    ctrl_m_d.mem_write = ctrl_e_q.mem_write;
    ctrl_m_d.mem2reg   = ctrl_e_q.mem2reg;
    ctrl_w_d           = '0;
    ctrl_w_d.reg_write = ctrl_m_q.reg_write;
    ctrl_w_d.mem2reg   = ctrl_m_q.mem2reg;
    illegal_d          = illegal_q | dec_illegal;
  end

  // Stage control registers; reset drops all in-flight control so no partial write can follow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_e_q  <= CTRL_NOP;
      ctrl_m_q  <= '0;
      ctrl_w_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_e_q  <= ctrl_e_d;
      ctrl_m_q  <= ctrl_m_d;
      ctrl_w_q  <= ctrl_w_d;
      illegal_q <= illegal_d;
    end
  end

  // Each datapath control comes from the stage that consumes it.
  assign pcu.regDst     = ctrl_e_q.reg_dst;
  assign pcu.aluSrcB    = ctrl_e_q.alu_src_b;
  assign pcu.aluControl = ALU_CW'(ctrl_e_q.alu_ctl);
  assign pcu.fad        = fad_sel;
  assign pcu.fbd        = fbd_sel;
  assign pcu.memWrite   = ctrl_m_q.mem_write;
  assign pcu.regWrite   = ctrl_w_q.reg_write;
  assign pcu.mem2Reg    = ctrl_w_q.mem2reg;
  assign pcu.pcSrc      = pc_src;
  assign pcu.flush      = pc_src;
  assign pcu.stall      = stall_hz;
  assign pcu.illegal    = illegal_q;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Scoreboard bench for pipeline_ctrl_unit: directed hazard scenarios then random instruction streams.
// Expected outputs come from an instruction-level pipeline model; a monitor compares every cycle.
// Inputs are driven on the falling edge; outputs are sampled 2 ns later.
module tb_pipeline_ctrl_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_ctrl_unit_if #(.REG_AW(5), .ALU_CW(3)) bus ();

  pipeline_ctrl_unit #(.REG_AW(5), .ALU_CW(3), .BNE_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .pcu (bus)
  );

  // What an instruction means, per the ISA table
  typedef struct packed {
    bit       bad;
    bit       rw;
    bit       rd;
    bit       src;
    bit       br;
    bit       bne;
    bit       mw;
    bit       m2r;
    bit [2:0] alu;
  } ictl_t;

  // One cycle of expected outputs
  typedef struct packed {
    logic [2:0] alu;
    logic       rd;
    logic       src;
    logic       mw;
    logic       rw;
    logic       m2r;
    logic       pc;
    logic       fl;
    logic       st;
    logic       il;
    logic [1:0] fad;
    logic [1:0] fbd;
  } exp_t;

  exp_t  exp_q[$];
  ictl_t in_ex  = '0;
  ictl_t in_mem = '0;
  ictl_t in_wb  = '0;
  bit    ill_seen   = 1'b0;
  bit    last_stall = 1'b0;
  int    checks   = 0;
  int    failures = 0;

  function automatic ictl_t decode(input bit [5:0] op, input bit [5:0] fn);
    ictl_t c;
    c = '0;
    case (op)
      6'h00: begin
        c.rw = 1'b1;
        c.rd = 1'b1;
        case (fn)
          6'h20:   c.alu = 3'b010;
          6'h22:   c.alu = 3'b110;
          6'h24:   c.alu = 3'b000;
          6'h25:   c.alu = 3'b001;
          6'h2A:   c.alu = 3'b111;
          default: begin c = '0; c.bad = 1'b1; end
        endcase
      end
      6'h23: begin c.rw = 1'b1; c.src = 1'b1; c.m2r = 1'b1; c.alu = 3'b010; end
      6'h2B: begin c.mw = 1'b1; c.src = 1'b1; c.alu = 3'b010; end
      6'h08: begin c.rw = 1'b1; c.src = 1'b1; c.alu = 3'b010; end
      6'h04: begin c.br = 1'b1; c.alu = 3'b110; end
      6'h05: begin c.br = 1'b1; c.bne = 1'b1; c.alu = 3'b110; end
      default: c.bad = 1'b1;
    endcase
    return c;
  endfunction

  function automatic bit [1:0] fwd(input int src, input int wm, input int ww, input bit rwm, input bit rww);
    if (rwm && wm != 0 && wm == src) return 2'b10;
    if (rww && ww != 0 && ww == src) return 2'b01;
    return 2'b00;
  endfunction

  // One clock of stimulus: drive, record this cycle's expected outputs, advance the model across the edge.
  task automatic step(input bit r, input int op, input int fn, input int rsd, input int rtd,
                      input int rse, input int rte, input int wm, input int ww, input bit z);
    exp_t  e;
    ictl_t d;
    @(negedge clk);
    rst           = r;
    bus.opD       = 6'(op);
    bus.functD    = 6'(fn);
    bus.rsD       = 5'(rsd);
    bus.rtD       = 5'(rtd);
    bus.rsE       = 5'(rse);
    bus.rtE       = 5'(rte);
    bus.writeRegM = 5'(wm);
    bus.writeRegW = 5'(ww);
    bus.zeroE     = z;

    e     = '0;
    e.alu = in_ex.alu;
    e.rd  = in_ex.rd;
    e.src = in_ex.src;
    e.mw  = in_mem.mw;
    e.rw  = in_wb.rw;
    e.m2r = in_wb.m2r;
    e.pc  = in_ex.br && (z != in_ex.bne);
    e.fl  = e.pc;
    e.st  = !e.pc && in_ex.m2r && rte != 0 && (rte == rsd || rte == rtd);
    e.il  = ill_seen;
    e.fad = fwd(rse, wm, ww, in_mem.rw, in_wb.rw);
    e.fbd = fwd(rte, wm, ww, in_mem.rw, in_wb.rw);
    exp_q.push_back(e);
    last_stall = e.st;

    d = decode(6'(op), 6'(fn));
    if (!r) begin
      in_ex    = '0;
      in_mem   = '0;
      in_wb    = '0;
      ill_seen = 1'b0;
    end else begin
      in_wb    = in_mem;
      in_mem   = in_ex;
      in_ex    = (e.pc || e.st) ? ictl_t'('0) : d;
      ill_seen = ill_seen | d.bad;
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regDst",     4'(bus.regDst),     4'(e.rd));
        chk("aluSrcB",    4'(bus.aluSrcB),    4'(e.src));
        chk("aluControl", 4'(bus.aluControl), 4'(e.alu));
        chk("memWrite",   4'(bus.memWrite),   4'(e.mw));
        chk("regWrite",   4'(bus.regWrite),   4'(e.rw));
        chk("mem2Reg",    4'(bus.mem2Reg),    4'(e.m2r));
        chk("pcSrc",      4'(bus.pcSrc),      4'(e.pc));
        chk("flush",      4'(bus.flush),      4'(e.fl));
        chk("stall",      4'(bus.stall),      4'(e.st));
        chk("illegal",    4'(bus.illegal),    4'(e.il));
        chk("fad",        4'(bus.fad),        4'(e.fad));
        chk("fbd",        4'(bus.fbd),        4'(e.fbd));
      end
    end
  end

  initial begin : driver
    int op, fn, rsd, rtd, pick;
    bit hold, rflag;
    int legal_ops[6];
    int functs[5];
    legal_ops = '{32'h00, 32'h23, 32'h2B, 32'h08, 32'h04, 32'h05};
    functs    = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};

    rst = 1'b0;
    bus.opD = '0; bus.functD = '0; bus.rsD = '0; bus.rtD = '0;
    bus.rsE = '0; bus.rtE = '0; bus.writeRegM = '0; bus.writeRegW = '0; bus.zeroE = 1'b0;
    @(posedge clk);

    // Reset held: everything must read zero
    step(0, 'h08, 0, 0, 0, 0, 0, 0, 0, 0);

    // R-type add: EX controls next cycle, regWrite three cycles later
    step(1, 'h00, 'h20, 1, 2, 0, 0, 0, 0, 0);
    step(1, 'h08, 0,    0, 0, 1, 2, 0, 0, 0);
    step(1, 'h08, 0,    0, 0, 0, 0, 3, 0, 0);
    step(1, 'h08, 0,    0, 0, 0, 0, 0, 3, 0);

    // add $8 then dependants: MEM forward, WB forward, writeRegM=0 not forwarded
    step(1, 'h00, 'h20, 1, 2, 0, 0, 0, 0, 0);
    step(1, 'h00, 'h22, 8, 2, 1, 2, 0, 0, 0);
    step(1, 'h00, 'h24, 8, 3, 8, 2, 8, 0, 0);
    step(1, 'h08, 0,    0, 0, 8, 3, 9, 8, 0);
    step(1, 'h08, 0,    0, 0, 0, 0, 0, 9, 0);

    // lw $9 followed by a consumer of $9: one stall, bubble, then WB forward
    step(1, 'h23, 0,    1, 9, 0, 0, 0, 0, 0);
    step(1, 'h00, 'h20, 9, 4, 1, 9, 0, 0, 0);
    step(1, 'h00, 'h20, 9, 4, 0, 0, 9, 0, 0);
    step(1, 'h08, 0,    0, 0, 9, 4, 0, 9, 0);

    // beq taken, beq not taken, bne taken
    step(1, 'h04, 0, 1, 2, 0, 0, 0, 0, 0);
    step(1, 'h08, 0, 0, 0, 1, 2, 0, 0, 1);
    step(1, 'h08, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 'h04, 0, 1, 2, 0, 0, 0, 0, 0);
    step(1, 'h08, 0, 0, 0, 1, 2, 0, 0, 0);
    step(1, 'h05, 0, 1, 2, 0, 0, 0, 0, 0);
    step(1, 'h08, 0, 0, 0, 1, 2, 0, 0, 0);

    // load-use on a branch in ID, then the branch resolves taken
    step(1, 'h23, 0, 1, 5, 0, 0, 0, 0, 0);
    step(1, 'h04, 0, 5, 5, 1, 5, 0, 0, 1);
    step(1, 'h04, 0, 5, 5, 0, 0, 5, 0, 1);
    step(1, 'h08, 0, 0, 0, 5, 5, 0, 5, 1);

    // Illegal opcode is sticky; reset mid-stream clears everything
    step(1, 'h3F, 0,    0, 0, 0, 0, 0, 0, 0);
    step(1, 'h23, 0,    1, 6, 0, 0, 0, 0, 0);
    step(1, 'h00, 'h20, 2, 3, 1, 6, 0, 0, 0);
    step(1, 'h2B, 0,    1, 2, 2, 3, 6, 0, 0);
    step(0, 'h08, 0,    0, 0, 1, 2, 7, 6, 0);
    step(1, 'h08, 0,    0, 0, 0, 0, 0, 0, 0);
    step(1, 'h08, 0,    0, 0, 0, 0, 0, 0, 0);

    // Random streams over a small register range so hazards are frequent
    hold = 1'b0;
    op = 'h08; fn = 0; rsd = 0; rtd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        pick = int'($urandom_range(0, 199));
        if (pick == 0)      op = 'h3F;
        else if (pick == 1) op = 'h02;
        else                op = legal_ops[$urandom_range(0, 5)];
        fn  = (pick == 2) ? 'h21 : functs[$urandom_range(0, 4)];
        rsd = int'($urandom_range(0, 3));
        rtd = int'($urandom_range(0, 3));
      end
      rflag = ($urandom_range(0, 39) != 0);
      step(rflag, op, fn, rsd, rtd,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
      hold = last_stall && rflag;
    end

    // Let the monitor consume the last expectation, bounded
    repeat (2) @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
